// File: rtl/ipa_rx_fifo.sv
// Serial word receiver feeding a Wishbone-readable FIFO with STATUS and sticky OVF/FERR flags.
// Word visible one cycle after its last stop bit; reads ack one cycle after request; FIFO overflow drops words.
module ipa_rx_fifo #(
    parameter int BYTES      = 2,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic               cyc_i,
    input  logic               stb_i,
    input  logic               we_i,
    input  logic               adr_i,
    input  logic [8*BYTES-1:0] dat_i,
    output logic               ack_o,
    output logic [8*BYTES-1:0] dat_o,
    input  logic               txd_i,
    input  logic               txc_i,
    output logic               irq_o
);
    localparam int W     = 8 * BYTES;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;

    logic txd_s1_q, txd_s2_q, txc_s1_q, txc_s2_q, txc_prev_q;
    state_t state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic [1:0] byte_idx_q, byte_idx_d;
    logic [W-1:0] word_q, word_d;
    logic push, ferr_set, smp;

    logic [W-1:0] mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr_q, rptr_q;
    logic [DEPTH_LOG2:0] count_q, count_d;
    logic ovf_q, ovf_d, ferr_q, ferr_d, ack_q, ack_d;
    logic [W-1:0] dat_q, dat_d, status;
    logic full, empty, req, pop, push_ok, ovf_set, clr_wr;
    logic unused_dat;

    assign unused_dat = ^dat_i;

    // Sample on the falling edge of the synchronized serial clock.
    assign smp = txc_prev_q & ~txc_s2_q;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        push       = 1'b0;
        ferr_set   = 1'b0;
        if (smp) begin
            case (state_q)
                IDLE: if (!txd_s2_q) begin
                    state_d   = DATA;
                    bit_cnt_d = 3'd0;
                end
                DATA: begin
                    shreg_d   = {txd_s2_q, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (txd_s2_q) begin
                        for (int b = 0; b < BYTES; b++)
                            if (byte_idx_q == 2'(b)) word_d[b*8 +: 8] = shreg_q;
                        if (byte_idx_q == 2'(BYTES - 1)) begin
                            push       = 1'b1;
                            byte_idx_d = 2'd0;
                        end else begin
                            byte_idx_d = byte_idx_q + 2'd1;
                        end
                    end else begin
                        ferr_set   = 1'b1;
                        byte_idx_d = 2'd0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign full    = (count_q == (DEPTH_LOG2 + 1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign req     = cyc_i & stb_i & ~ack_q;
    assign pop     = req & ~we_i & ~adr_i & ~empty;
    assign push_ok = push & (~full | pop);
    assign ovf_set = push & full & ~pop;
    assign clr_wr  = req & we_i & adr_i;

    always_comb begin
        status                     = '0;
        status[0]                  = ~empty;
        status[1]                  = full;
        status[2]                  = ovf_q;
        status[3]                  = ferr_q;
        status[4 +: DEPTH_LOG2+1]  = count_q;
    end

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // A flag being set this cycle wins over a software clear.
        ovf_d  = ovf_set  | (ovf_q  & ~(clr_wr & dat_i[2]));
        ferr_d = ferr_set | (ferr_q & ~(clr_wr & dat_i[3]));
        ack_d  = req;
        dat_d  = '0;
        if (req) begin
            if (adr_i)       dat_d = status;
            else if (pop)    dat_d = mem_q[rptr_q];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            txd_s1_q   <= 1'b1;
            txd_s2_q   <= 1'b1;
            txc_s1_q   <= 1'b1;
            txc_s2_q   <= 1'b1;
            txc_prev_q <= 1'b1;
            state_q    <= IDLE;
            bit_cnt_q  <= 3'd0;
            shreg_q    <= 8'd0;
            byte_idx_q <= 2'd0;
            word_q     <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            ferr_q     <= 1'b0;
            ack_q      <= 1'b0;
            dat_q      <= '0;
        end else begin
            txd_s1_q   <= txd_i;
            txd_s2_q   <= txd_s1_q;
            txc_s1_q   <= txc_i;
            txc_s2_q   <= txc_s1_q;
            txc_prev_q <= txc_s2_q;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop)     rptr_q <= rptr_q + 1'b1;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            ferr_q     <= ferr_d;
            ack_q      <= ack_d;
            dat_q      <= dat_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wptr_q] <= word_d;
    end

    assign ack_o = ack_q;
    assign dat_o = dat_q;
    assign irq_o = ~empty | ovf_q | ferr_q;
endmodule

// File: tb/tb_ipa_rx_fifo.sv
module tb_ipa_rx_fifo;
    logic        clk = 1'b0;
    logic        reset_ni = 1'b0;
    logic        cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0, adr_i = 1'b0;
    logic [15:0] dat_i = '0;
    logic        ack_o;
    logic [15:0] dat_o;
    logic        txd_i = 1'b1, txc_i = 1'b1;
    logic        irq_o;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;
    logic [15:0] exp_q [$];

    ipa_rx_fifo #(.BYTES(2), .DEPTH_LOG2(2)) dut (
        .clk_i(clk), .reset_ni(reset_ni), .cyc_i(cyc_i), .stb_i(stb_i),
        .we_i(we_i), .adr_i(adr_i), .dat_i(dat_i), .ack_o(ack_o),
        .dat_o(dat_o), .txd_i(txd_i), .txc_i(txc_i), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    // Monitor: every ack pops one expected read value; dat_o must be 0 otherwise.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (ack_o) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ack: dat_o=%h, no read pending", dat_o);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    if (dat_o !== e) begin
                        errors++;
                        $display("FAIL read_data: got %h expected %h", dat_o, e);
                    end
                end
            end else if (dat_o !== 16'h0) begin
                errors++;
                $display("FAIL idle_dat: got %h expected 0000", dat_o);
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drain_chk();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL ack_timeout: %0d reads pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wb(input logic adr, input logic we, input logic [15:0] wd, input logic [15:0] exp);
        @(negedge clk);
        cyc_i = 1'b1; stb_i = 1'b1; adr_i = adr; we_i = we; dat_i = wd;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; dat_i = '0;
        drain_chk();
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk); txd_i = b; txc_i = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk); txc_i = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic send_data_bits(input logic [7:0] b);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stopb);
        send_data_bits(b);
        send_bit(stopb);
        @(negedge clk); txc_i = 1'b1; txd_i = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic send_word(input logic [15:0] w);
        send_byte(w[7:0], 1'b1);
        send_byte(w[15:8], 1'b1);
    endtask

    // Last stop bit is timed so its sample lands on the same edge as a DATA read.
    task automatic send_word_with_pop(input logic [15:0] w, input logic [15:0] exp_pop);
        send_byte(w[7:0], 1'b1);
        send_data_bits(w[15:8]);
        @(negedge clk); txd_i = 1'b1; txc_i = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk); txc_i = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        cyc_i = 1'b1; stb_i = 1'b1; adr_i = 1'b0; we_i = 1'b0;
        exp_q.push_back(exp_pop);
        @(posedge clk);
        #1;
        cyc_i = 1'b0; stb_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); txc_i = 1'b1;
        drain_chk();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_ni = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ack", {15'h0, ack_o}, 16'h0);
        chk("reset_dat", dat_o, 16'h0);
        chk("reset_irq", {15'h0, irq_o}, 16'h0);
        reset_ni = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
        wb(1'b1, 1'b0, 16'h0, 16'h0000);

        // Basic word
        send_word(16'h1234);
        @(negedge clk);
        chk("irq_nonempty", {15'h0, irq_o}, 16'h1);
        wb(1'b1, 1'b0, 16'h0, 16'h0011);
        wb(1'b0, 1'b0, 16'h0, 16'h1234);
        wb(1'b1, 1'b0, 16'h0, 16'h0000);
        @(negedge clk);
        chk("irq_empty", {15'h0, irq_o}, 16'h0);

        // Empty read
        wb(1'b0, 1'b0, 16'h0, 16'h0000);
        wb(1'b1, 1'b0, 16'h0, 16'h0000);
        wb(1'b0, 1'b1, 16'hFFFF, 16'h0000);

        // Overflow
        send_word(16'h1111);
        send_word(16'h2222);
        send_word(16'h3333);
        send_word(16'h4444);
        send_word(16'h5555);
        wb(1'b1, 1'b0, 16'h0, 16'h0047);
        wb(1'b0, 1'b0, 16'h0, 16'h1111);
        wb(1'b0, 1'b0, 16'h0, 16'h2222);
        wb(1'b0, 1'b0, 16'h0, 16'h3333);
        wb(1'b0, 1'b0, 16'h0, 16'h4444);
        wb(1'b1, 1'b0, 16'h0, 16'h0004);
        @(negedge clk);
        chk("irq_ovf", {15'h0, irq_o}, 16'h1);
        wb(1'b1, 1'b1, 16'h0004, 16'h0004);
        wb(1'b1, 1'b0, 16'h0, 16'h0000);

        // Push while full coinciding with a pop
        send_word(16'h0101);
        send_word(16'h0202);
        send_word(16'h0303);
        send_word(16'h0404);
        send_word_with_pop(16'h0505, 16'h0101);
        wb(1'b1, 1'b0, 16'h0, 16'h0043);
        wb(1'b0, 1'b0, 16'h0, 16'h0202);
        wb(1'b0, 1'b0, 16'h0, 16'h0303);
        wb(1'b0, 1'b0, 16'h0, 16'h0404);
        wb(1'b0, 1'b0, 16'h0, 16'h0505);
        wb(1'b1, 1'b0, 16'h0, 16'h0000);

        // Framing error in second byte
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        wb(1'b1, 1'b0, 16'h0, 16'h0008);
        @(negedge clk);
        chk("irq_ferr", {15'h0, irq_o}, 16'h1);
        send_word(16'hBEEF);
        wb(1'b1, 1'b0, 16'h0, 16'h0019);
        wb(1'b0, 1'b0, 16'h0, 16'hBEEF);
        wb(1'b1, 1'b1, 16'h0008, 16'h0008);
        wb(1'b1, 1'b0, 16'h0, 16'h0000);

        // Held request acks every second cycle
        @(negedge clk);
        cyc_i = 1'b1; stb_i = 1'b1; adr_i = 1'b1; we_i = 1'b0;
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0000);
        repeat (4) @(posedge clk);
        #1;
        cyc_i = 1'b0; stb_i = 1'b0;
        drain_chk();

        // Reset mid-word
        send_word(16'h9999);
        send_byte(8'h77, 1'b1);
        @(negedge clk); reset_ni = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("midreset_irq", {15'h0, irq_o}, 16'h0);
        reset_ni = 1'b1;
        repeat (2) @(posedge clk);
        wb(1'b1, 1'b0, 16'h0, 16'h0000);
        send_byte(8'hCD, 1'b1);
        send_byte(8'hAB, 1'b1);
        wb(1'b0, 1'b0, 16'h0, 16'hABCD);
        wb(1'b1, 1'b0, 16'h0, 16'h0000);

        repeat (4) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
